handshake_assert_monitor: RTL



---
 rtl/handshake_assert_monitor_if.sv | 15 +
 rtl/handshake_assert_monitor.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/handshake_assert_monitor_if.sv
// rtl/handshake_assert_monitor_if.sv - valid/ready channel bundle observed by the assertion monitor
interface handshake_assert_monitor_if #(
    parameter int NCHAN = 4,
    parameter int W     = 32
);
    logic [NCHAN-1:0]   ch_valid;
    logic [NCHAN-1:0]   ch_ready;
    logic [NCHAN*W-1:0] ch_data;
    logic [NCHAN*W-1:0] ch_expect;
    logic [NCHAN-1:0]   ch_bypass;

    modport master (output ch_valid, ch_data, ch_expect, ch_bypass, input ch_ready);
    modport slave  (input ch_valid, ch_data, ch_expect, ch_bypass, output ch_ready);
    modport mon    (input ch_valid, ch_ready, ch_data, ch_expect, ch_bypass);
endinterface

// File: rtl/handshake_assert_monitor.sv
// rtl/handshake_assert_monitor.sv - multi-channel valid/ready protocol checker with sticky flags and error count
module handshake_assert_monitor #(
    parameter int NCHAN    = 4,
    parameter int W        = 32,
    parameter int TIMEOUT  = 64,
    parameter int CNTW     = 8,
    parameter int FATAL_EN = 1,
    localparam int CIW     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    handshake_assert_monitor_if.mon  ch,
    input  logic                     clear,
    output logic [NCHAN-1:0]         err_sticky,
    output logic                     err_any,
    output logic [CIW-1:0]           first_chan,
    output logic [1:0]               first_code,
    output logic [CNTW-1:0]          err_count
);
    // Timer parks at TIMEOUT+1 so the equality match fires once per wait episode
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam logic [TW-1:0] TO_V = TW'(TIMEOUT);
    localparam logic [TW-1:0] TSAT = TW'(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    logic [2*NCHAN-1:0] code_vec;
    logic [NCHAN-1:0]   err_mask;

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        state_t         state_q, state_d;
        logic [W-1:0]   hold_q, hold_d;
        logic [TW-1:0]  timer_q, timer_d;
        logic [1:0]     code;
        logic           v, r, byp;
        logic [W-1:0]   d, e;

        assign v   = ch.ch_valid[i];
        assign r   = ch.ch_ready[i];
        assign byp = ch.ch_bypass[i];
        assign d   = ch.ch_data[i*W +: W];
        assign e   = ch.ch_expect[i*W +: W];

        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            timer_d = timer_q;
            case (state_q)
                S_IDLE: begin
                    if (v && !r) begin
                        state_d = S_WAIT;
                        hold_d  = d;
                        timer_d = TW'(1);
                    end
                end
                S_WAIT: begin
                    if (!v || r) begin
                        state_d = S_IDLE;
                    end else if (d != hold_q) begin
                        hold_d = d;
                    end else if (!byp && timer_q != TSAT) begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Priority within a channel: mismatch, then stability, then timeout
        always_comb begin
            code = 2'd0;
            if (!byp) begin
                if (v && r && d != e) begin
                    code = 2'd1;
                end else if (state_q == S_WAIT && (!v || (!r && d != hold_q))) begin
                    code = 2'd2;
                end else if (TIMEOUT != 0 && state_q == S_WAIT && v && !r && timer_q == TO_V) begin
                    code = 2'd3;
                end
            end
        end

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                state_q <= S_IDLE;
                hold_q  <= '0;
                timer_q <= '0;
            end else begin
                state_q <= state_d;
                hold_q  <= hold_d;
                timer_q <= timer_d;
            end
        end

        assign code_vec[2*i +: 2] = code;
        assign err_mask[i]        = (code != 2'd0);
    end

    logic           any_new;
    logic [CIW-1:0] sel_chan;
    logic [1:0]     sel_code;

    always_comb begin
        any_new  = |err_mask;
        sel_chan = '0;
        sel_code = 2'd0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (err_mask[i]) begin
                sel_chan = CIW'(i);
                sel_code = code_vec[2*i +: 2];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            err_sticky <= '0;
            first_chan <= '0;
            first_code <= 2'd0;
            err_count  <= '0;
        end else if (clear) begin
            err_sticky <= err_mask;
            first_chan <= any_new ? sel_chan : '0;
            first_code <= any_new ? sel_code : 2'd0;
            err_count  <= any_new ? CNTW'(1) : '0;
        end else begin
            err_sticky <= err_sticky | err_mask;
            if (any_new && first_code == 2'd0) begin
                first_chan <= sel_chan;
                first_code <= sel_code;
            end
            if (any_new && err_count != {CNTW{1'b1}}) begin
                err_count <= err_count + CNTW'(1);
            end
        end
    end

    assign err_any = |err_sticky;

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (reset_n) begin
            for (int i = 0; i < NCHAN; i++) begin
                if (err_mask[i]) begin
                    $display("handshake_assert_monitor: chan %0d code %0d", i, code_vec[2*i +: 2]);
                    if (FATAL_EN != 0) $fatal(1, "handshake_assert_monitor: stop on chan %0d", i);
                end
            end
        end
    end
`endif
endmodule
